// File: rtl/mdu.sv
// mdu: multiply/divide unit with private HI/LO registers and a busy counter.
// Optional trace output (PC port, write log) is enabled by defining MDU_TRACE_EN.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
`ifdef MDU_TRACE_EN
    input  logic [31:0] PC,
`endif
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    localparam logic [3:0] MUL_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

    logic [3:0]  cnt;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        dz;

    logic        accept;
    logic        is_mul;
    logic        is_div;
    logic        is_mthi;
    logic        is_mtlo;
    logic        sgn_mul;
    logic        sgn_div;
    logic        commit;

    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;

    logic        neg_a;
    logic        neg_b;
    logic        b_zero;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quo;
    logic [31:0] rem;

    assign busy = (cnt != 4'd0);

    // Decode the request and qualify it against the busy counter.
    always_comb begin
        is_mul  = 1'b0;
        is_div  = 1'b0;
        is_mthi = 1'b0;
        is_mtlo = 1'b0;
        sgn_mul = 1'b0;
        sgn_div = 1'b0;
        case (op)
            OP_MULT:  begin is_mul = 1'b1; sgn_mul = 1'b1; end
            OP_MULTU: is_mul = 1'b1;
            OP_DIV:   begin is_div = 1'b1; sgn_div = 1'b1; end
            OP_DIVU:  is_div = 1'b1;
            OP_MTHI:  is_mthi = 1'b1;
            OP_MTLO:  is_mtlo = 1'b1;
            default:  ;
        endcase
        accept = start && !busy;
        commit = (cnt == 4'd1) && !dz;
    end

    // 64-bit product; low 64 bits of an extended multiply suit both signednesses.
    always_comb begin
        ext_a = sgn_mul ? {{32{src_a[31]}}, src_a} : {32'b0, src_a};
        ext_b = sgn_mul ? {{32{src_b[31]}}, src_b} : {32'b0, src_b};
        prod  = ext_a * ext_b;
    end

    // Sign-magnitude divide: truncating quotient, remainder follows dividend.
    always_comb begin
        neg_a   = sgn_div && src_a[31];
        neg_b   = sgn_div && src_b[31];
        b_zero  = (src_b == 32'd0);
        mag_a   = neg_a ? (~src_a + 32'd1) : src_a;
        mag_b   = neg_b ? (~src_b + 32'd1) : src_b;
        divisor = b_zero ? 32'd1 : mag_b;
        uq      = mag_a / divisor;
        ur      = mag_a % divisor;
        quo     = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
        rem     = neg_a ? (~ur + 32'd1) : ur;
    end

    // Accept requests, run the busy counter and commit pending results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi     <= 32'd0;
            lo     <= 32'd0;
            cnt    <= 4'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            dz     <= 1'b0;
        end else if (accept) begin
            unique case (1'b1)
                is_mul: begin
                    res_hi <= prod[63:32];
                    res_lo <= prod[31:0];
                    dz     <= 1'b0;
                    cnt    <= MUL_LOAD;
                end
                is_div: begin
                    res_hi <= rem;
                    res_lo <= quo;
                    dz     <= b_zero;
                    cnt    <= DIV_LOAD;
                end
                is_mthi: hi <= src_a;
                is_mtlo: lo <= src_a;
                default: ;
            endcase
        end else if (busy) begin
            cnt <= cnt - 4'd1;
            if (commit) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

`ifdef MDU_TRACE_EN
    logic [31:0] pc_q;

    // Latch the PC of the accepted request and log every HI/LO write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= 32'd0;
        end else if (accept) begin
            pc_q <= PC;
            if (is_mthi) $display("@%h: HI <= %h", PC, src_a);
            if (is_mtlo) $display("@%h: LO <= %h", PC, src_a);
        end else if (busy && commit) begin
            $display("@%h: HI <= %h", pc_q, res_hi);
            $display("@%h: LO <= %h", pc_q, res_lo);
        end
    end
`endif

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed and randomized checks of mdu against an arithmetic model.
// Model uses 64-bit integer math; busy length and hi/lo are compared per op.
module tb_mdu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic [31:0] pc = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    mdu dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
`ifdef MDU_TRACE_EN
        .PC    (pc),
`endif
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int exp_busy(input logic [2:0] o);
        if (o == 3'd0 || o == 3'd1) return 5;
        if (o == 3'd2 || o == 3'd3) return 10;
        return 0;
    endfunction

    // Reference: apply the architectural effect of one op to the model.
    task automatic model(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (o)
            3'd0: begin
                p = longint'(sa * sb);
                hi_m = p[63:32]; lo_m = p[31:0];
            end
            3'd1: begin
                p = ua * ub;
                hi_m = p[63:32]; lo_m = p[31:0];
            end
            3'd2: if (b != 0) begin
                q = sa / sb; r = sa % sb;
                hi_m = r[31:0]; lo_m = q[31:0];
            end
            3'd3: if (b != 0) begin
                hi_m = a % b; lo_m = a / b;
            end
            3'd4: hi_m = a;
            3'd5: lo_m = a;
            default: ;
        endcase
    endtask

    // Issue one op, count busy cycles, optionally spray ignored starts.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input bit junk);
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1; n++;
        end
        start = 1'b1; op = o; src_a = a; src_b = b;
        pc = pc + 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        src_a = $urandom; src_b = $urandom;
        n = 0;
        while (busy && n < 40) begin
            n++;
            check({tag, "_hold_hi"}, hi, hi_m);
            check({tag, "_hold_lo"}, lo, lo_m);
            if (junk) begin
                start = 1'b1;
                op = 3'($urandom_range(0, 7));
                src_a = $urandom; src_b = $urandom;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check({tag, "_busy_cycles"}, 32'(n), 32'(exp_busy(o)));
        model(o, a, b);
        check({tag, "_hi"}, hi, hi_m);
        check({tag, "_lo"}, lo, lo_m);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        #12;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        run_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("mult_neg_hi_const", hi, 32'hFFFF_FFFF);
        check("mult_neg_lo_const", lo, 32'hFFFF_FFFA);

        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_hi_const", hi, 32'hFFFF_FFFE);
        check("multu_lo_const", lo, 32'h0000_0001);

        run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_lo_const", lo, 32'hFFFF_FFFD);
        check("div_hi_const", hi, 32'hFFFF_FFFF);

        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf_lo_const", lo, 32'h8000_0000);
        check("div_ovf_hi_const", hi, 32'h0000_0000);

        run_op("mthi", 3'd4, 32'h1234_5678, 32'd0, 1'b0);
        run_op("divu_junk", 3'd3, 32'd100, 32'd7, 1'b1);
        check("divu_lo_const", lo, 32'd14);
        check("divu_hi_const", hi, 32'd2);

        run_op("mtlo", 3'd5, 32'hCAFE_BABE, 32'd0, 1'b0);
        check("mtlo_const", lo, 32'hCAFE_BABE);

        run_op("preset_hi", 3'd4, 32'h0000_00AA, 32'd0, 1'b0);
        run_op("preset_lo", 3'd5, 32'h0000_00BB, 32'd0, 1'b0);
        run_op("divu_zero", 3'd3, 32'h1234_0000, 32'd0, 1'b0);
        check("divz_hi_const", hi, 32'h0000_00AA);
        check("divz_lo_const", lo, 32'h0000_00BB);

        run_op("rsvd", 3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'hFF;
            run_op($sformatf("rnd%0d", i), ro, ra, rb, ($urandom_range(0, 1) == 1));
        end

        start = 1'b1; op = 3'd0; src_a = 32'd9; src_b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        check("rst_mid_busy_before", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        @(posedge clk); #2;
        reset = 1'b1;
        hi_m = 32'd0; lo_m = 32'd0;
        repeat (8) @(posedge clk);
        #1;
        check("rst_after_busy", {31'b0, busy}, 32'd0);
        check("rst_after_hi", hi, 32'd0);
        check("rst_after_lo", lo, 32'd0);

        run_op("post_rst_mult", 3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
